// File: rtl/axi4lite_master_bridge.sv
// -----------------------------------------------------------------------------
// axi4lite_master_bridge
//
// Single-outstanding AXI4-Lite master. Turns a simple valid/ready command and
// response handshake into one AXI4-Lite write or read transaction at a time.
// Used by a debug host / UART decoder to reach the soc_control register map.
//
// Optional feature macro: AXI4LITE_MASTER_TIMEOUT_EN
//   When defined, a watchdog counter forces a 2'b11 response after
//   TIMEOUT_CYCLES cycles stuck in a request/response state. This recovery
//   path drops VALIDs before their handshake and is not AXI-compliant.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   cmd_*           : command in (valid/ready, we, addr, wdata, wstrb)
//   rsp_*           : response out (valid/ready, rdata, resp)
//   busy            : high whenever the bridge is not idle
//   M_AXI_*         : AXI4-Lite master channels AW, W, B, AR, R
// -----------------------------------------------------------------------------
module axi4lite_master_bridge #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256,
   localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_we,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic [1:0]            rsp_resp,
   output logic                  busy,

   output logic                  M_AXI_AWVALID,
   input  logic                  M_AXI_AWREADY,
   output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
   output logic [2:0]            M_AXI_AWPROT,

   output logic                  M_AXI_WVALID,
   input  logic                  M_AXI_WREADY,
   output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
   output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,

   input  logic                  M_AXI_BVALID,
   output logic                  M_AXI_BREADY,
   input  logic [1:0]            M_AXI_BRESP,

   output logic                  M_AXI_ARVALID,
   input  logic                  M_AXI_ARREADY,
   output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
   output logic [2:0]            M_AXI_ARPROT,

   input  logic                  M_AXI_RVALID,
   output logic                  M_AXI_RREADY,
   input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
   input  logic [1:0]            M_AXI_RRESP
);

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] WR_REQ  = 3'd1;
   localparam logic [2:0] WR_RESP = 3'd2;
   localparam logic [2:0] RD_REQ  = 3'd3;
   localparam logic [2:0] RD_RESP = 3'd4;
   localparam logic [2:0] RSP     = 3'd5;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic [2:0]            state;
   logic                  out_of_rst;   // keeps cmd_ready low while in reset
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  aw_done, w_done;
   logic                  awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
   logic                  rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic [1:0]            rsp_resp_q;
   logic                  aw_hs, w_hs;

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] tmo_cnt;
`endif

   assign aw_hs = awvalid_q && M_AXI_AWREADY;
   assign w_hs  = wvalid_q  && M_AXI_WREADY;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         out_of_rst  <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         aw_done     <= 1'b0;
         w_done      <= 1'b0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= 2'b00;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
         tmo_cnt     <= '0;
`endif
      end else begin
         out_of_rst <= 1'b1;
         case (state)
            IDLE: begin
               if (cmd_valid && out_of_rst) begin
                  addr_q  <= cmd_addr;
                  wdata_q <= cmd_wdata;
                  wstrb_q <= cmd_wstrb;
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
                  tmo_cnt <= '0;
`endif
                  if (cmd_we) begin
                     state     <= WR_REQ;
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     aw_done   <= 1'b0;
                     w_done    <= 1'b0;
                  end else begin
                     state     <= RD_REQ;
                     arvalid_q <= 1'b1;
                  end
               end
            end
            WR_REQ: begin
               if (aw_hs) begin
                  awvalid_q <= 1'b0;
                  aw_done   <= 1'b1;
               end
               if (w_hs) begin
                  wvalid_q <= 1'b0;
                  w_done   <= 1'b1;
               end
               // Leave as soon as both sides are done, counting a handshake
               // that lands on this very edge.
               if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                  state    <= WR_RESP;
                  bready_q <= 1'b1;
               end
            end
            WR_RESP: begin
               if (M_AXI_BVALID) begin
                  bready_q    <= 1'b0;
                  rsp_resp_q  <= M_AXI_BRESP;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= 1'b1;
                  state       <= RSP;
               end
            end
            RD_REQ: begin
               if (M_AXI_ARREADY) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= RD_RESP;
               end
            end
            RD_RESP: begin
               if (M_AXI_RVALID) begin
                  rready_q    <= 1'b0;
                  rsp_rdata_q <= M_AXI_RDATA;
                  rsp_resp_q  <= M_AXI_RRESP;
                  rsp_valid_q <= 1'b1;
                  state       <= RSP;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
         // Watchdog: placed after the case so its assignments take priority
         // over any handshake that happens on the same edge.
         if (state == WR_REQ || state == WR_RESP ||
             state == RD_REQ || state == RD_RESP) begin
            if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES)) begin
               awvalid_q   <= 1'b0;
               wvalid_q    <= 1'b0;
               bready_q    <= 1'b0;
               arvalid_q   <= 1'b0;
               rready_q    <= 1'b0;
               rsp_resp_q  <= 2'b11;
               rsp_rdata_q <= '0;
               rsp_valid_q <= 1'b1;
               state       <= RSP;
            end else begin
               tmo_cnt <= tmo_cnt + CNT_W'(1);
            end
         end
`endif
      end
   end

   assign cmd_ready     = (state == IDLE) && out_of_rst;
   assign busy          = (state != IDLE);

   assign rsp_valid     = rsp_valid_q;
   assign rsp_rdata     = rsp_rdata_q;
   assign rsp_resp      = rsp_resp_q;

   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_AWADDR  = addr_q;
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_WDATA   = wdata_q;
   assign M_AXI_WSTRB   = wstrb_q;
   assign M_AXI_BREADY  = bready_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_ARADDR  = addr_q;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// -----------------------------------------------------------------------------
// tb_axi4lite_master_bridge
//
// Directed bench for axi4lite_master_bridge with a small AXI4-Lite slave
// (16-word register file, programmable AW/W/AR stalls, optional B suppression).
// -----------------------------------------------------------------------------
module tb_axi4lite_master_bridge;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready, cmd_we;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, busy;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic [2:0]  awprot, arprot;
   logic [1:0]  bresp, rresp;

   always #5 clk = ~clk;

   axi4lite_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_resp(rsp_resp), .busy(busy),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr),
      .M_AXI_AWPROT(awprot),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
      .M_AXI_WSTRB(wstrb),
      .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr),
      .M_AXI_ARPROT(arprot),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata),
      .M_AXI_RRESP(rresp)
   );

   // ---------------- slave model ----------------
   int          aw_delay = 0, w_delay = 0, ar_delay = 0;
   logic        no_b = 1'b0;
   int          aw_cnt, w_cnt, ar_cnt;
   logic        aw_got, w_got;
   logic [31:0] aw_addr_q, w_data_q;
   logic [3:0]  w_strb_q;
   logic [31:0] mem [16];

   assign awready = awvalid && !aw_got && (aw_cnt >= aw_delay);
   assign wready  = wvalid  && !w_got  && (w_cnt  >= w_delay);
   assign arready = arvalid && (ar_cnt >= ar_delay);
   assign bresp   = 2'b00;
   assign rresp   = 2'b00;

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin : slave
      logic        aw_n, w_n;
      logic [31:0] a_n, d_n;
      logic [3:0]  s_n;
      if (rst) begin
         aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0; rdata <= '0;
         aw_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
         for (int i = 0; i < 16; i++) mem[i] <= '0;
      end else begin
         aw_n = aw_got || (awvalid && awready);
         w_n  = w_got  || (wvalid && wready);
         a_n  = (awvalid && awready) ? awaddr : aw_addr_q;
         d_n  = (wvalid && wready) ? wdata : w_data_q;
         s_n  = (wvalid && wready) ? wstrb : w_strb_q;
         aw_addr_q <= a_n; w_data_q <= d_n; w_strb_q <= s_n;
         if (awvalid && !awready && !aw_got) aw_cnt <= aw_cnt + 1;
         if (wvalid && !wready && !w_got) w_cnt <= w_cnt + 1;
         if (aw_n && w_n && !bvalid && !no_b) begin
            mem[a_n[5:2]] <= merge(mem[a_n[5:2]], d_n, s_n);
            bvalid <= 1'b1;
            aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
         end else begin
            aw_got <= aw_n; w_got <= w_n;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (arvalid && arready) begin
            rdata  <= mem[araddr[5:2]];
            rvalid <= 1'b1;
            ar_cnt <= 0;
         end else if (arvalid) begin
            ar_cnt <= ar_cnt + 1;
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   // ---------------- checking ----------------
   int n_cmp = 0, n_bad = 0;
   logic aw_tr [32], w_tr [32], b_tr [32];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issue one command from idle, record per-cycle AW/W/B valids/readies,
   // optionally hold rsp_ready low for 'hold' cycles, then complete.
   // lat = cycle index (counted from the acceptance edge) where rsp_valid is seen.
   task automatic do_cmd(input logic we, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold,
                         output logic [31:0] rd, output logic [1:0] rr, output int lat);
      chk("cmd_ready_idle", cmd_ready, 1);
      cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         cmd_valid = 1'b0;
         lat++;
         if (lat < 32) begin
            aw_tr[lat] = awvalid; w_tr[lat] = wvalid; b_tr[lat] = bready;
         end
      end while (!rsp_valid && lat < 100);
      if (!rsp_valid) chk("rsp_wait_bound", 0, 1);
      rd = rsp_rdata; rr = rsp_resp;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_rsp_valid", rsp_valid, 1);
         chk("hold_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("hold_cmd_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   logic [31:0] rd;
   logic [1:0]  rr;
   int          lat;

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
      cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 6'b0);
      chk("rst_rsp", {rsp_rdata, rsp_resp}, 34'h0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_cmd_ready", cmd_ready, 1);
      chk("prot", {awprot, arprot}, 6'b0);
      @(negedge clk);

      // full write / read-back, zero-wait slave
      do_cmd(1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 0, rd, rr, lat);
      chk("wr_resp", rr, 2'b00);
      chk("wr_rdata_zero", rd, 32'h0);
      chk("wr_latency", lat, 3);
      do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, rr, lat);
      chk("rd_data", rd, 32'hDEADBEEF);
      chk("rd_resp", rr, 2'b00);
      chk("rd_latency", lat, 3);

      // partial write
      do_cmd(1'b1, 32'h8, 32'hFFFFFFFF, 4'hF, 0, rd, rr, lat);
      do_cmd(1'b1, 32'h8, 32'h00AA5500, 4'b0110, 0, rd, rr, lat);
      do_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, rr, lat);
      chk("partial_rd", rd, 32'hFFAA55FF);

      // W stalled 3 cycles after AW
      aw_delay = 0; w_delay = 3;
      do_cmd(1'b1, 32'hC, 32'h12345678, 4'hF, 0, rd, rr, lat);
      chk("wlate_aw_c1", aw_tr[1], 1);
      chk("wlate_aw_drop", aw_tr[2], 0);
      chk("wlate_w_c4", w_tr[4], 1);
      chk("wlate_w_drop", w_tr[5], 0);
      chk("wlate_b_early", {b_tr[2], b_tr[3], b_tr[4]}, 3'b000);
      chk("wlate_b_rise", b_tr[5], 1);
      chk("wlate_latency", lat, 6);

      // AW stalled 3 cycles after W
      aw_delay = 3; w_delay = 0;
      do_cmd(1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 0, rd, rr, lat);
      chk("awlate_w_drop", w_tr[2], 0);
      chk("awlate_aw_c4", aw_tr[4], 1);
      chk("awlate_aw_drop", aw_tr[5], 0);
      chk("awlate_b_early", {b_tr[2], b_tr[3], b_tr[4]}, 3'b000);
      chk("awlate_b_rise", b_tr[5], 1);
      aw_delay = 0;
      do_cmd(1'b0, 32'hC, 32'h0, 4'h0, 0, rd, rr, lat);
      chk("wlate_readback", rd, 32'h12345678);
      do_cmd(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, rr, lat);
      chk("awlate_readback", rd, 32'hCAFEF00D);

      // response backpressure
      do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 5, rd, rr, lat);
      chk("bp_rdata", rd, 32'hDEADBEEF);

      // reset while ARVALID is high
      ar_delay = 10;
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h4;
      @(posedge clk);
      @(negedge clk); cmd_valid = 1'b0;
      @(negedge clk);
      chk("mid_arvalid", arvalid, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, busy}, 7'b0);
      chk("mid_rst_rsp", {rsp_rdata, rsp_resp}, 34'h0);
      @(negedge clk); rst = 1'b0; ar_delay = 0;
      @(posedge clk); #1;
      chk("mid_idle", {cmd_ready, busy}, 2'b10);
      @(negedge clk);
      do_cmd(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, rr, lat);
      chk("mid_after_rd", rd, 32'h0);

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
      no_b = 1'b1;
      do_cmd(1'b1, 32'h14, 32'h55AA55AA, 4'hF, 0, rd, rr, lat);
      chk("tmo_latency", lat, 17);
      chk("tmo_resp", rr, 2'b11);
      chk("tmo_rdata", rd, 32'h0);
      chk("tmo_valids", {aw_tr[17], w_tr[17], b_tr[17]}, 3'b000);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
